// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: byte width and default receive buffer depth, so
// receiver, FIFO and consumers agree on sizing.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: circular buffer with
// first-word-fall-through valid/ready output, fill level and sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_overflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic              drop;

  assign empty     = (count == '0);
  assign full      = (count == (ADDR_W+1)'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  // A full buffer still accepts a byte when a pop frees a slot on the same edge.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for the basic push/pop
// flow plus hand-written sequences for full, overflow, wrap and reset cases.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_overflow;

  int vectors     = 0;
  int miscompares = 0;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    int         cnt;
    logic       vld;
    logic       dchk;
    logic [7:0] dat;
    logic       ovf;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(logic r, logic iv, logic [7:0] d, logic rdy,
                              logic clr, int cnt, logic vld, logic dchk,
                              logic [7:0] dat, logic ovf);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.rdy = rdy; v.clr = clr;
    v.cnt = cnt; v.vld = vld; v.dchk = dchk; v.dat = dat; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Apply inputs for one rising edge, then settle just after it.
  task automatic step(input logic r, input logic iv, input logic [7:0] d,
                      input logic rdy, input logic clr);
    rst = r; in_valid = iv; in_data = d; out_ready = rdy; clr_overflow = clr;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic chk_level(input string name, input int exp_cnt);
    chk({name, ".count"}, int'(count), exp_cnt);
    chk({name, ".empty"}, int'(empty), int'(exp_cnt == 0));
    chk({name, ".full"}, int'(full), int'(exp_cnt == 16));
    chk({name, ".out_valid"}, int'(out_valid), int'(exp_cnt != 0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;

    // rst iv data rdy clr | cnt vld dchk dat ovf
    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
    tbl[1]  = mk(0, 1, 8'h41, 0, 0, 1, 1, 1, 8'h41, 0);
    tbl[2]  = mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 8'h41, 0);
    tbl[3]  = mk(0, 1, 8'h42, 0, 0, 2, 1, 1, 8'h41, 0);
    tbl[4]  = mk(0, 1, 8'h43, 0, 0, 3, 1, 1, 8'h41, 0);
    tbl[5]  = mk(0, 0, 8'h00, 1, 0, 2, 1, 1, 8'h42, 0);
    tbl[6]  = mk(0, 0, 8'h00, 1, 0, 1, 1, 1, 8'h43, 0);
    tbl[7]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
    tbl[8]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
    tbl[9]  = mk(0, 1, 8'h50, 1, 0, 1, 1, 1, 8'h50, 0);
    tbl[10] = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d.count", i), int'(count), tbl[i].cnt);
      chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(tbl[i].vld));
      chk($sformatf("vec%0d.empty", i), int'(empty), int'(tbl[i].cnt == 0));
      chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(tbl[i].ovf));
      if (tbl[i].dchk) chk($sformatf("vec%0d.out_data", i), int'(out_data), int'(tbl[i].dat));
    end

    // Fill to 16, drop 0xFF, drain in order.
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0);
    chk_level("fill16", 16);
    step(0, 1, 8'hFF, 0, 0);
    chk_level("drop", 16);
    chk("drop.overflow", int'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.out_data", i), int'(out_data), i);
      step(0, 0, 8'h00, 1, 0);
    end
    chk_level("drained", 0);
    chk("drained.overflow", int'(overflow), 1);
    step(0, 0, 8'h00, 0, 1);
    chk("clr.overflow", int'(overflow), 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
    step(0, 1, 8'hAA, 1, 0);
    chk_level("fullpp", 16);
    chk("fullpp.overflow", int'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpp_drain%0d", i), int'(out_data), (i == 15) ? 8'hAA : 8'h11 + i);
      step(0, 0, 8'h00, 1, 0);
    end
    chk_level("fullpp_end", 0);

    // Streaming 40 bytes so both pointers wrap twice.
    step(0, 1, 8'h80, 0, 0);
    chk_level("stream0", 1);
    for (int k = 1; k < 40; k++) begin
      chk($sformatf("stream%0d.out_data", k), int'(out_data), 8'h80 + k - 1);
      step(0, 1, 8'(8'h80 + k), 1, 0);
      chk($sformatf("stream%0d.count", k), int'(count), 1);
    end
    chk("stream_last.out_data", int'(out_data), 8'h80 + 39);
    step(0, 0, 8'h00, 1, 0);
    chk_level("stream_end", 0);

    // Overflow set wins over a same-cycle clear.
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 1, 8'hEE, 0, 0);
    chk("ovf_set", int'(overflow), 1);
    step(0, 1, 8'hEF, 0, 1);
    chk("ovf_set_vs_clr", int'(overflow), 1);
    step(0, 0, 8'h00, 0, 1);
    chk("ovf_clr", int'(overflow), 0);
    chk_level("ovf_hold_count", 16);

    // Reset mid-operation with a push pending, overflow raised beforehand.
    step(0, 1, 8'hEE, 0, 0);
    chk("pre_rst.overflow", int'(overflow), 1);
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0, 0);
    chk_level("five", 5);
    step(1, 1, 8'h77, 1, 1);
    chk_level("rst_mid", 0);
    chk("rst_mid.overflow", int'(overflow), 0);
    step(0, 1, 8'h55, 0, 0);
    chk_level("after_rst", 1);
    chk("after_rst.out_data", int'(out_data), 8'h55);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte buffer directly downstream of the UART receiver. Captures each single-cycle received-byte strobe into a circular buffer and presents bytes to the consumer (command parser / display logic) over a valid/ready handshake, so bytes are not lost while the consumer is busy. Reports fill level and flags bytes dropped when full with a sticky overflow.

## Interface
- DATA_W, 8, byte width; matches the receiver's data output.
- DEPTH, 16, number of entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

- clk  input  1  system clock; sole clock domain.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  DATA_W  received byte; sampled only when in_valid=1.
- in_valid  input  1  single-cycle strobe from the receiver's ready output; no backpressure upstream.
- out_data  output  DATA_W  oldest buffered byte; meaningful only when out_valid=1.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  consumer accepts out_data; a pop occurs when out_valid & out_ready.
- count  output  ADDR_W+1  entries held, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; set when a byte is dropped.
- clr_overflow  input  1  clears overflow.

## Operation
- Storage: DEPTH x DATA_W register array; write pointer wr_ptr, read pointer rd_ptr, both ADDR_W bits, wrapping naturally modulo DEPTH (DEPTH-1 -> 0).
- Push: in_valid=1 and (full=0 or pop this cycle) -> mem[wr_ptr]<=in_data, wr_ptr++.
- Pop: out_valid=1 and out_ready=1 -> rd_ptr++.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- Full + in_valid + pop same cycle: push and pop both accepted, count stays DEPTH, no overflow.
- Full + in_valid, no pop: byte dropped, pointers/count unchanged, overflow<=1.
- Empty + in_valid: push accepted. No pop is possible that cycle because out_valid=0. No bypass.
- out_ready while empty: ignored.
- overflow: set has priority over clr_overflow in the same cycle. Otherwise clr_overflow=1 clears it. Otherwise it holds.
- No state machine; behaviour is fully defined by pointers, count and the overflow flag.
- Reset: wr_ptr=0, rd_ptr=0, count=0, overflow=0. Hence out_valid=0, empty=1, full=0. Array contents are not reset; out_data is don't-care while out_valid=0. Reset mid-operation discards all buffered bytes and has priority over any simultaneous push, pop or clr_overflow.

## Timing
- out_data = mem[rd_ptr], read combinationally (first-word-fall-through).
- Latency: byte pushed on edge N -> out_valid=1 and out_data valid after edge N, i.e. during cycle N+1.
- out_valid, empty, full and count derive from registered count; no combinational path from in_valid or out_ready to any output.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- Back-to-back pops are permitted every cycle. Back-to-back pushes are permitted every cycle, although the receiver strobes at most once per frame.
- After a pop on edge N, the next entry appears during cycle N+1.

## Structure
- Single module, no sub-module; the array and pointers are inline.
- A shared UART defines header holds DATA_W (8) and the default DEPTH, so receiver, FIFO and consumers agree on byte width.
- count width ADDR_W+1 is derived locally; no separate full/empty registers.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on separate cycles with out_ready=0 -> count=3, out_data=0x41, out_valid=1 one cycle after the first push; then out_ready=1 for 3 cycles -> 0x41, 0x42, 0x43 in order, then empty=1, count=0.
- Push 16 bytes 0x00..0x0F -> full=1, count=16. A 17th push 0xFF with no pop -> overflow=1, count=16. Drain -> 0x00..0x0F, 0xFF absent.
- With full=1, push 0xAA while popping the same cycle -> count stays 16, overflow=0, and 0xAA is the last byte drained.
- Push and pop 40 bytes continuously so pointers wrap twice -> output sequence equals input sequence and count never exceeds 1.
- Raise overflow, then assert clr_overflow on the same cycle as another dropped push -> overflow stays 1; clr_overflow next cycle -> overflow=0.
- Assert rst with 5 bytes buffered and in_valid=1 -> next cycle count=0, empty=1, out_valid=0, overflow=0; a subsequent push 0x55 appears as the first output.
